add_req_arb: RTL and testbench

- Upstream front-end for the single-precision addsub unit.
- Accepts add/subtract requests from NUM_CLIENTS independent requesters (e.g. series-evaluation sequencers), picks one by round-robin, and drives the addsub start/done/serv handshake.
- Returns the result to the owning client as a one-cycle response pulse.
- Exactly one transaction is in flight at a time; addsub is never overrun.

---
 rtl/add_arb_pkg.sv | 23 ++
 rtl/add_req_arb_rr_arbiter.sv | 35 +++
 rtl/add_req_arb.sv | 149 ++++++++++++++
 tb/tb_add_req_arb.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_arb_pkg.sv
// add_arb_pkg: shared FSM state encoding and IEEE-754 single field helpers
// for the addsub request arbiter.
package add_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int FP_W     = 32;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_W   = 23;

  // True for +0 and -0 (exponent and mantissa all zero, sign ignored).
  function automatic logic is_zero(input logic [FP_W-1:0] fp);
    return (fp[EXP_MSB:EXP_LSB] == '0) && (fp[MANT_W-1:0] == '0);
  endfunction

endpackage

// File: rtl/add_req_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Scans from last_grant+1
// upward modulo NUM_CLIENTS and reports the first requesting client as a
// one-hot vector plus its index. The caller registers the result.
module rr_arbiter
  import add_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int IDX_W       = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]       last_grant,
  output logic [NUM_CLIENTS-1:0] gnt,
  output logic [IDX_W-1:0]       idx,
  output logic                   found
);

  int cand;

  // Rotating priority scan; the client just served is checked last.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      cand = (int'(last_grant) + k) % NUM_CLIENTS;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                 = 1'b1;
        idx                   = cand[IDX_W-1:0];
        gnt[cand[IDX_W-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_req_arb.sv
// add_req_arb: round-robin front-end for the single-precision addsub unit.
// One transaction in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
// Optional feature macro ADD_ARB_ZERO_BYPASS_EN: requests with a zero
// operand are answered directly (IDLE -> RESP) without touching addsub.
module add_req_arb
  import add_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_W      = 32
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [NUM_CLIENTS-1:0]        req,
  input  logic [NUM_CLIENTS*DATA_W-1:0] req_op1,
  input  logic [NUM_CLIENTS*DATA_W-1:0] req_op2,
  input  logic [NUM_CLIENTS-1:0]        req_sub,
  output logic [NUM_CLIENTS-1:0]        req_gnt,
  output logic [NUM_CLIENTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]             rsp_result,
  output logic                          arb_busy,
  output logic [DATA_W-1:0]             op1,
  output logic [DATA_W-1:0]             op2,
  output logic                          add_start,
  output logic                          add_serv,
  input  logic                          add_busy,
  input  logic                          add_done,
  input  logic [DATA_W-1:0]             add_result
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);

  arb_state_t             state;
  logic [IDX_W-1:0]       last_grant;
  logic [IDX_W-1:0]       owner;
  logic                   serv_pend;

  logic [NUM_CLIENTS-1:0] win_gnt;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_found;
  logic [DATA_W-1:0]      sel_a;
  logic [DATA_W-1:0]      sel_b;

  rr_arbiter #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (IDX_W)
  ) u_rr (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (win_gnt),
    .idx        (win_idx),
    .found      (win_found)
  );

  // Effective operands of the winning client; subtract flips B's sign only.
  always_comb begin
    sel_a           = req_op1[win_idx*DATA_W +: DATA_W];
    sel_b           = req_op2[win_idx*DATA_W +: DATA_W];
    sel_b[SIGN_BIT] = sel_b[SIGN_BIT] ^ req_sub[win_idx];
  end

`ifdef ADD_ARB_ZERO_BYPASS_EN
  logic              byp_hit;
  logic [DATA_W-1:0] byp_res;

  // x + 0 = x; 0 + 0 is -0 only when both zeros are negative.
  always_comb begin
    byp_hit = is_zero(sel_a) || is_zero(sel_b);
    if (is_zero(sel_a) && is_zero(sel_b))
      byp_res = {sel_a[SIGN_BIT] & sel_b[SIGN_BIT], {(DATA_W-1){1'b0}}};
    else if (is_zero(sel_a))
      byp_res = sel_b;
    else
      byp_res = sel_a;
  end
`endif

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_CLIENTS - 1);
      owner      <= '0;
      serv_pend  <= 1'b0;
      req_gnt    <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      arb_busy   <= 1'b0;
      op1        <= '0;
      op2        <= '0;
      add_start  <= 1'b0;
      add_serv   <= 1'b0;
    end else begin
      req_gnt   <= '0;
      rsp_valid <= '0;
      add_start <= 1'b0;
      add_serv  <= 1'b0;
      unique case (state)
        IDLE: begin
          arb_busy <= 1'b0;
          if (win_found) begin
            op1        <= sel_a;
            op2        <= sel_b;
            owner      <= win_idx;
            last_grant <= win_idx;
            req_gnt    <= win_gnt;
            arb_busy   <= 1'b1;
`ifdef ADD_ARB_ZERO_BYPASS_EN
            if (byp_hit) begin
              rsp_result <= byp_res;
              serv_pend  <= 1'b0;
              state      <= RESP;
            end else begin
              state      <= ISSUE;
            end
`else
            state <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          arb_busy <= 1'b1;
          if (!add_busy) begin
            add_start <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          arb_busy <= 1'b1;
          if (add_done) begin
            rsp_result <= add_result;
            serv_pend  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= NUM_CLIENTS'(1) << owner;
          add_serv  <= serv_pend;
          arb_busy  <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_req_arb.sv
// tb_add_req_arb: table-driven and scoreboarded bench for add_req_arb with a
// behavioural addsub stand-in that answers known operand pairs from a table.
module tb_add_req_arb;

  localparam int NC = 4;
  localparam int DW = 32;

  logic             clk;
  logic             n_rst;
  logic [NC-1:0]    req;
  logic [NC*DW-1:0] req_op1;
  logic [NC*DW-1:0] req_op2;
  logic [NC-1:0]    req_sub;
  logic [NC-1:0]    req_gnt;
  logic [NC-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_result;
  logic             arb_busy;
  logic [DW-1:0]    op1;
  logic [DW-1:0]    op2;
  logic             add_start;
  logic             add_serv;
  logic             add_busy;
  logic             add_done;
  logic [DW-1:0]    add_result;

  add_req_arb #(.NUM_CLIENTS(NC), .DATA_W(DW)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .req        (req),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_sub    (req_sub),
    .req_gnt    (req_gnt),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .arb_busy   (arb_busy),
    .op1        (op1),
    .op2        (op2),
    .add_start  (add_start),
    .add_serv   (add_serv),
    .add_busy   (add_busy),
    .add_done   (add_done),
    .add_result (add_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          owner;
    logic [31:0] res;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] eb;
    logic [31:0] er;
    int          d;
  } vec_t;
  vec_t vt[7];

  // Known sums for the operand pairs the bench uses (B already sign-adjusted).
  function automatic logic [31:0] lut(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40200000 && b == 32'h40600000) return 32'h40C00000;
    if (a == 32'h40880000 && b == 32'hC0800000) return 32'h3E800000;
    if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
    if (a == 32'h40400000 && b == 32'h3F800000) return 32'h40800000;
    if (a == 32'h00000000 && b == 32'h41480000) return 32'h41480000;
    if (a == 32'h80000000 && b == 32'h80000000) return 32'h80000000;
    if (a == 32'h41200000 && b == 32'h40A00000) return 32'h41700000;
    if (a == 32'hC0000000 && b == 32'h40000000) return 32'h00000000;
    return 32'hDEADBEEF;
  endfunction

  function automatic logic byp_exp(input logic [31:0] a, input logic [31:0] eb);
`ifdef ADD_ARB_ZERO_BYPASS_EN
    return (a[30:0] == 31'd0) || (eb[30:0] == 31'd0);
`else
    return (a[30:0] == 31'd0) && (eb[30:0] == 31'd0) && 1'b0;
`endif
  endfunction

  // addsub stand-in: answers mdl_delay cycles after each start pulse.
  int mdl_delay = 2;
  int n_starts  = 0;
  initial begin
    logic [31:0] cap_a;
    logic [31:0] cap_b;
    add_done   = 1'b0;
    add_result = '0;
    forever begin
      @(negedge clk);
      if (add_start === 1'b1) begin
        n_starts++;
        cap_a = op1;
        cap_b = op2;
        repeat (mdl_delay) @(negedge clk);
        add_done   = 1'b1;
        add_result = lut(cap_a, cap_b);
        @(negedge clk);
        add_done   = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: sim time exceeded, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_client(input int c, input logic [31:0] a, input logic [31:0] b,
                            input logic s);
    req_op1[c*DW +: DW] = a;
    req_op2[c*DW +: DW] = b;
    req_sub[c]          = s;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_gnt"},   32'(req_gnt),   0);
    chk({tag, "_rspv"},  32'(rsp_valid), 0);
    chk({tag, "_res"},   rsp_result,     0);
    chk({tag, "_busy"},  32'(arb_busy),  0);
    chk({tag, "_op1"},   op1,            0);
    chk({tag, "_op2"},   op2,            0);
    chk({tag, "_start"}, 32'(add_start), 0);
    chk({tag, "_serv"},  32'(add_serv),  0);
  endtask

  task automatic check_rsp(input logic serv_exp);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_rsp", 32'(rsp_valid), 0);
      return;
    end
    e = sb.pop_front();
    chk("rsp_owner",  32'(rsp_valid), 32'(1) << e.owner);
    chk("rsp_result", rsp_result,     e.res);
    chk("add_serv",   32'(add_serv),  32'(serv_exp));
  endtask

  // Called just after the edge that shows add_start; lat counts edges to rsp.
  task automatic wait_rsp(input int lat);
    int n;
    n = 0;
    while (n < 200 && rsp_valid == '0) begin
      @(posedge clk); #1;
      n++;
    end
    if (rsp_valid == '0) begin
      chk("rsp_timeout", 32'(rsp_valid), 1);
      return;
    end
    chk("rsp_latency", n, lat);
    check_rsp(1'b1);
  endtask

  task automatic run_txn(input vec_t v);
    int   starts0;
    logic byp;
    byp       = byp_exp(v.a, v.eb);
    mdl_delay = v.d;
    @(negedge clk);
    set_client(v.c, v.a, v.b, v.s);
    req[v.c] = 1'b1;
    sb.push_back('{v.c, v.er});
    starts0 = n_starts;
    @(posedge clk); #1;
    chk("gnt", 32'(req_gnt), 32'(1) << v.c);
    req[v.c] = 1'b0;
    @(posedge clk); #1;
    if (!byp) begin
      chk("start", 32'(add_start), 1);
      chk("op1",   op1, v.a);
      chk("op2",   op2, v.eb);
      chk("busy",  32'(arb_busy), 1);
      wait_rsp(v.d + 2);
    end else begin
      check_rsp(1'b0);
      chk("bypass_no_start", n_starts, starts0);
    end
    @(posedge clk); #1;
    chk("rsp_one_cycle", 32'(rsp_valid), 0);
    chk("idle_not_busy", 32'(arb_busy), 0);
  endtask

  // Two clients request together; cf is expected to win, cs follows.
  task automatic pair_txn(input int cf, input logic [31:0] af, input logic [31:0] bf,
                          input logic sf, input logic [31:0] ebf, input logic [31:0] erf,
                          input int cs, input logic [31:0] as, input logic [31:0] bs,
                          input logic ss, input logic [31:0] ebs, input logic [31:0] ers);
    mdl_delay = 2;
    @(negedge clk);
    set_client(cf, af, bf, sf);
    set_client(cs, as, bs, ss);
    req[cf] = 1'b1;
    req[cs] = 1'b1;
    sb.push_back('{cf, erf});
    sb.push_back('{cs, ers});
    @(posedge clk); #1;
    chk("pair_gnt_first", 32'(req_gnt), 32'(1) << cf);
    req[cf] = 1'b0;
    @(posedge clk); #1;
    chk("pair_start1", 32'(add_start), 1);
    chk("pair_op2_1",  op2, ebf);
    wait_rsp(4);
    @(posedge clk); #1;
    chk("pair_gnt_second", 32'(req_gnt), 32'(1) << cs);
    chk("pair_rsp_gap",    32'(rsp_valid), 0);
    req[cs] = 1'b0;
    @(posedge clk); #1;
    chk("pair_start2", 32'(add_start), 1);
    chk("pair_op2_2",  op2, ebs);
    wait_rsp(4);
  endtask

  initial begin
    int   starts0;
    logic seen;
    vt[0] = '{0, 32'h40200000, 32'h40600000, 1'b0, 32'h40600000, 32'h40C00000, 3};
    vt[1] = '{1, 32'h40880000, 32'h40800000, 1'b1, 32'hC0800000, 32'h3E800000, 1};
    vt[2] = '{3, 32'h3F800000, 32'h3F800000, 1'b0, 32'h3F800000, 32'h40000000, 2};
    vt[3] = '{2, 32'h40400000, 32'hBF800000, 1'b1, 32'h3F800000, 32'h40800000, 4};
    vt[4] = '{0, 32'h00000000, 32'h41480000, 1'b0, 32'h41480000, 32'h41480000, 2};
    vt[5] = '{1, 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 32'h80000000, 2};
    vt[6] = '{0, 32'h41200000, 32'h40A00000, 1'b0, 32'h40A00000, 32'h41700000, 5};

    n_rst    = 1'b0;
    req      = '0;
    req_op1  = '0;
    req_op2  = '0;
    req_sub  = '0;
    add_busy = 1'b0;
    #3;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("post_reset");

    for (int i = 0; i < 7; i++) run_txn(vt[i]);

    // last_grant is 0 here: client 2 must beat client 0.
    pair_txn(2, 32'hC0000000, 32'hC0000000, 1'b1, 32'h40000000, 32'h00000000,
             0, 32'h41200000, 32'h40A00000, 1'b0, 32'h40A00000, 32'h41700000);

    // addsub busy for five cycles while the request waits in ISSUE.
    mdl_delay = 2;
    add_busy  = 1'b1;
    @(negedge clk);
    set_client(3, 32'h3F800000, 32'h3F800000, 1'b0);
    req[3] = 1'b1;
    sb.push_back('{3, 32'h40000000});
    @(posedge clk); #1;
    chk("busy_gnt", 32'(req_gnt), 32'h8);
    req[3]  = 1'b0;
    starts0 = n_starts;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("busy_no_start", 32'(add_start), 0);
      chk("busy_op1",      op1, 32'h3F800000);
      chk("busy_op2",      op2, 32'h3F800000);
      chk("busy_arb_busy", 32'(arb_busy), 1);
    end
    add_busy = 1'b0;
    @(posedge clk); #1;
    chk("busy_start", 32'(add_start), 1);
    wait_rsp(4);
    chk("busy_one_start", n_starts - starts0, 1);

    // Reset while waiting for addsub: transaction vanishes, client 0 first after.
    mdl_delay = 20;
    @(negedge clk);
    set_client(1, 32'h3F800000, 32'h3F800000, 1'b0);
    req[1] = 1'b1;
    @(posedge clk); #1;
    chk("rst_gnt", 32'(req_gnt), 32'h2);
    req[1] = 1'b0;
    @(posedge clk); #1;
    chk("rst_start", 32'(add_start), 1);
    @(posedge clk); #2;
    n_rst = 1'b0;
    #1;
    check_outputs_zero("mid_wait_rst");
    @(negedge clk);
    n_rst = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (rsp_valid != '0) seen = 1'b1;
    end
    chk("no_rsp_after_rst", 32'(seen), 0);
    chk("no_stray_capture", rsp_result, 0);
    pair_txn(0, 32'h40200000, 32'h40600000, 1'b0, 32'h40600000, 32'h40C00000,
             3, 32'h3F800000, 32'h3F800000, 1'b0, 32'h3F800000, 32'h40000000);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
